// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
// Mode 0 only: CPOL=0, CPHA=0, MSB first.
package spi_pkg;

  localparam int SPI_DATA_W_DEFAULT = 8;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEL  = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_slave_if_sync.sv
// Multi-flop synchronizer for one asynchronous pin.
// All flops reset to RST_VAL so the pin reads idle out of reset.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= {STAGES{RST_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 responder, pins oversampled in the clk domain.
// One-entry tx buffer, one-cycle rx strobes.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              tx_underrun_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic sck_s, cs_n_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sck_i),
    .q     (sck_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cs_n_i),
    .q     (cs_n_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (mosi_i),
    .q     (mosi_s)
  );

  logic sck_q, cs_n_q, mosi_q;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  // Edge pulses are registered; mosi_q is delayed to stay aligned with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      cs_fall  <= 1'b0;
      cs_rise  <= 1'b0;
    end else begin
      sck_q    <= sck_s;
      cs_n_q   <= cs_n_s;
      mosi_q   <= mosi_s;
      sck_rise <= sck_s & ~sck_q;
      sck_fall <= ~sck_s & sck_q;
      cs_fall  <= ~cs_n_s & cs_n_q;
      cs_rise  <= cs_n_s & ~cs_n_q;
    end
  end

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sin_q, sin_d;
  logic [DATA_W-1:0] sout_q, sout_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              tx_full_q, tx_full_d;
  logic              done_q, done_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              rx_valid_q, rx_valid_d;
  logic              under_q, under_d;
  logic              load, capture;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sin_d      = sin_q;
    sout_d     = sout_q;
    done_d     = done_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    under_d    = 1'b0;
    load       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_SEL;
          load    = 1'b1;
          cnt_d   = '0;
          sin_d   = '0;
          done_d  = 1'b0;
          oe_d    = 1'b1;
        end
      end
      ST_SEL: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
          miso_d  = 1'b0;
          cnt_d   = '0;
          sin_d   = '0;
          done_d  = 1'b0;
        end else if (sck_rise) begin
          sin_d = {sin_q[DATA_W-2:0], mosi_q};
          if (cnt_q == LAST) begin
            rx_data_d  = sin_d;
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            done_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (sck_fall) begin
          if (done_q) begin
            load   = 1'b1;
            done_d = 1'b0;
          end else begin
            sout_d = {sout_q[DATA_W-2:0], 1'b0};
            miso_d = sout_d[DATA_W-1];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An empty buffer at load time sends zeros and flags the underrun.
    if (load) begin
      sout_d  = tx_full_q ? tx_buf_q : '0;
      under_d = ~tx_full_q;
      miso_d  = sout_d[DATA_W-1];
    end
  end

  assign capture   = tx_valid_i & ~tx_full_q;
  assign tx_full_d = capture | (tx_full_q & ~load);
  assign tx_buf_d  = capture ? tx_data_i : tx_buf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sin_q      <= '0;
      sout_q     <= '0;
      done_q     <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      under_q    <= 1'b0;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sin_q      <= sin_d;
      sout_q     <= sout_d;
      done_q     <= done_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      under_q    <= under_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
    end
  end

  assign miso_o        = miso_q;
  assign miso_oe_o     = oe_q;
  assign tx_ready_o    = ~tx_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = under_q;
  assign busy_o        = (state_q == ST_SEL);

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomized bench for spi_slave_if: SPI master model,
// tx buffer model and an rx scoreboard drained by a monitor.
module tb_spi_slave_if;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int HALF = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sck = 1'b0;
  logic         cs_n = 1'b1;
  logic         mosi = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         miso_o, miso_oe_o, tx_ready_o;
  logic [W-1:0] rx_data_o;
  logic         rx_valid_o, tx_underrun_o, busy_o;

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(W), .SYNC_STAGES(S)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sck_i         (sck),
    .cs_n_i        (cs_n),
    .mosi_i        (mosi),
    .miso_o        (miso_o),
    .miso_oe_o     (miso_oe_o),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready_o),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .tx_underrun_o (tx_underrun_o),
    .busy_o        (busy_o)
  );

  int           n_cmp = 0;
  int           n_err = 0;
  int           und_seen = 0;
  int           und_exp = 0;
  logic [W-1:0] rx_exp_q[$];
  logic [W-1:0] tx_model[$];
  logic [W-1:0] wbuf[4];
  logic [W-1:0] pbuf[4];
  logic         pen[4];

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid_o) begin
        if (rx_exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rx_unexpected: got %0h expected no strobe @%0t",
                   rx_data_o, $time);
        end else begin
          check("rx_word", 16'(rx_data_o), 16'(rx_exp_q.pop_front()));
        end
      end
      if (tx_underrun_o) und_seen++;
    end
  end

  task automatic start_word(output logic [W-1:0] e);
    if (tx_model.size() != 0) begin
      e = tx_model.pop_front();
    end else begin
      e = '0;
      und_exp++;
    end
  endtask

  task automatic tx_push(input logic [W-1:0] v);
    check("tx_ready_pre", 16'(tx_ready_o), 16'(1));
    tx_data  = v;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tx_model.push_back(v);
    check("tx_ready_post", 16'(tx_ready_o), 16'(0));
  endtask

  task automatic send_word(input logic [W-1:0] w, input int nbits,
                           input bit end_cs, input bit push_en,
                           input logic [W-1:0] push_v,
                           output logic [W-1:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[W-1-i];
      if (push_en && i == 2) tx_push(push_v);
      tick(HALF);
      if (i == W - 1) rx_exp_q.push_back(w);
      got = {got[W-2:0], miso_o};
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
      if (end_cs && i == nbits - 1) cs_n = 1'b1;
    end
  endtask

  task automatic transfer(input int n, input int last_bits);
    logic [W-1:0] e, got;
    int nb;
    cs_n = 1'b0;
    tick(HALF);
    check("oe_sel", 16'(miso_oe_o), 16'(1));
    check("busy_sel", 16'(busy_o), 16'(1));
    for (int i = 0; i < n; i++) begin
      nb = (i == n - 1) ? last_bits : W;
      start_word(e);
      send_word(wbuf[i], nb, i == n - 1, pen[i] && (i < n - 1), pbuf[i], got);
      if (nb == W) check("miso_word", 16'(got), 16'(e));
    end
    tick(S + 2);
    check("oe_release", 16'(miso_oe_o), 16'(0));
    check("miso_idle", 16'(miso_o), 16'(0));
    check("busy_idle", 16'(busy_o), 16'(0));
    tick(4);
    check("underruns", 16'(und_seen), 16'(und_exp));
    check("tx_ready_idle", 16'(tx_ready_o), 16'(tx_model.size() == 0));
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = '0;
      pbuf[i] = '0;
      pen[i]  = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, 16'(miso_o), 16'(0));
    check({tag, "_oe"}, 16'(miso_oe_o), 16'(0));
    check({tag, "_ready"}, 16'(tx_ready_o), 16'(1));
    check({tag, "_rxdata"}, 16'(rx_data_o), 16'(0));
    check({tag, "_rxvalid"}, 16'(rx_valid_o), 16'(0));
    check({tag, "_under"}, 16'(tx_underrun_o), 16'(0));
    check({tag, "_busy"}, 16'(busy_o), 16'(0));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] e;
    int n;

    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(4);

    clear_plan();
    tx_push(8'hA5);
    wbuf[0] = 8'h3C;
    transfer(1, W);
    check("rx_hold_3c", 16'(rx_data_o), 16'(8'h3C));

    clear_plan();
    tx_push(8'h11);
    wbuf[0] = 8'hDE;
    wbuf[1] = 8'hAD;
    pen[0]  = 1'b1;
    pbuf[0] = 8'h22;
    transfer(2, W);

    clear_plan();
    wbuf[0] = 8'h55;
    transfer(1, W);
    check("rx_hold_55", 16'(rx_data_o), 16'(8'h55));

    clear_plan();
    wbuf[0] = W'($urandom);
    transfer(1, 5);
    check("rx_after_abort", 16'(rx_data_o), 16'(8'h55));
    clear_plan();
    wbuf[0] = 8'h81;
    transfer(1, W);

    for (int i = 0; i < 6; i++) begin
      sck = ~sck;
      tick(HALF);
      check("oe_cs_high", 16'(miso_oe_o), 16'(0));
    end
    sck = 1'b0;
    tick(HALF);
    check("rx_hold_81", 16'(rx_data_o), 16'(8'h81));

    tx_push(W'($urandom));
    cs_n = 1'b0;
    start_word(e);
    tick(HALF);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'($urandom);
      tick(HALF);
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    sck  = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    tx_model.delete();
    tick(3);
    rst_n = 1'b1;
    tick(4);
    clear_plan();
    wbuf[0] = 8'hF0;
    transfer(1, W);
    check("rx_hold_f0", 16'(rx_data_o), 16'(8'hF0));

    for (int k = 0; k < 6; k++) begin
      clear_plan();
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        wbuf[i] = W'($urandom);
        pbuf[i] = W'($urandom);
        pen[i]  = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 1) == 1) tx_push(W'($urandom));
      transfer(n, W);
    end

    tick(10);
    check("rx_queue_drained", 16'(rx_exp_q.size()), 16'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
